// File: rtl/gcd_unit_if.sv
// gcd_unit_if: operand/result handshake bundle for gcd_unit.
// master = operand producer / result consumer, slave = the GCD unit itself.
interface gcd_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out, busy
  );
endinterface

// File: rtl/gcd_unit.sv
// gcd_unit: subtractive-Euclid GCD engine with a valid/ready operand port
// and a valid/ready result port. One subtraction per clock in CALC.
// Optional feature: define GCD_ITER_COUNT_EN to add the iter_count output,
// a saturating count of subtraction steps of the current/last operation.
module gcd_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  gcd_unit_if.slave        bus
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
`endif

  // Next-state, datapath and registered-output decode for the GCD FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
`ifdef GCD_ITER_COUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          state_d = ST_CALC;
`ifdef GCD_ITER_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_CALC: begin
        // Zero and equality tests come first so the subtraction below is
        // always larger-minus-smaller and never wraps.
        if (a_q == '0) begin
          gcd_d   = b_q;
          state_d = ST_DONE;
        end else if (b_q == '0) begin
          gcd_d   = a_q;
          state_d = ST_DONE;
        end else if (a_q == b_q) begin
          gcd_d   = a_q;
          state_d = ST_DONE;
        end else begin
          if (a_q > b_q) begin
            a_d = a_q - b_q;
          end else begin
            b_d = b_q - a_q;
          end
`ifdef GCD_ITER_COUNT_EN
          if (cnt_q != '1) begin
            cnt_d = cnt_q + WIDTH'(1);
          end
`endif
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CALC);
    out_valid_d = (state_d == ST_DONE);
  end

  // State, operand, result and status-output registers; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      gcd_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gcd_q       <= gcd_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
`ifdef GCD_ITER_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.gcd_out   = gcd_q;

`ifdef GCD_ITER_COUNT_EN
  assign iter_count = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: self-checking bench for gcd_unit at WIDTH 16, 8 and 12.
// Expected results come from a modulo-based Euclid model; the subtraction
// step count is derived from the sum of Euclid quotients.
`timescale 1ns/1ps
module tb_gcd_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  gcd_unit_if #(.WIDTH(16)) if16 ();
  gcd_unit_if #(.WIDTH(8))  if8  ();
  gcd_unit_if #(.WIDTH(12)) if12 ();

`ifdef GCD_ITER_COUNT_EN
  logic [15:0] ic16;
  logic [7:0]  ic8;
  logic [11:0] ic12;
`endif

  gcd_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.slave)
`ifdef GCD_ITER_COUNT_EN
    , .iter_count(ic16)
`endif
  );

  gcd_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave)
`ifdef GCD_ITER_COUNT_EN
    , .iter_count(ic8)
`endif
  );

  gcd_unit #(.WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(if12.slave)
`ifdef GCD_ITER_COUNT_EN
    , .iter_count(ic12)
`endif
  );

  // ---------------- reference model ----------------
  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned x = a, y = b, t;
    if (x == 0) return y;
    if (y == 0) return x;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Subtractive Euclid performs q-1 subtractions for the final quotient
  // (it stops at equality) and q for every earlier one.
  function automatic longint unsigned ref_steps(input longint unsigned a, input longint unsigned b);
    longint unsigned x = a, y = b, t, n = 0;
    if (x == 0 || y == 0) return 0;
    while (y != 0) begin
      n += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    return n - 1;
  endfunction

  // ---------------- WIDTH=16 helpers ----------------
  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    checks++;
    if (if16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send16_in_ready got %0b want 1", if16.in_ready);
    end
    if16.a_in = a;
    if16.b_in = b;
    if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input string tag);
    int lat = 0;
    longint unsigned exp_lat, exp_g;
    exp_lat = ref_steps(a, b) + 1;
    exp_g   = ref_gcd(a, b);
    send16(a, b);
    do begin
      @(posedge clk); #1;
      lat++;
    end while (if16.out_valid !== 1'b1 && lat < 70000);
    checks++;
    if (lat != int'(exp_lat)) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", tag, lat, exp_lat);
    end
    checks++;
    if (if16.gcd_out !== 16'(exp_g)) begin
      errors++;
      $display("FAIL %s_gcd got %0d want %0d", tag, if16.gcd_out, exp_g);
    end
`ifdef GCD_ITER_COUNT_EN
    checks++;
    if (ic16 !== 16'(exp_lat - 1)) begin
      errors++;
      $display("FAIL %s_iter got %0d want %0d", tag, ic16, exp_lat - 1);
    end
`endif
    $display("op16 %s a=%0d b=%0d gcd=%0d latency=%0d", tag, a, b, if16.gcd_out, lat);
  endtask

  task automatic consume16();
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++;
    if (if16.out_valid !== 1'b0 || if16.busy !== 1'b0 || if16.gcd_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_during got ov=%0b busy=%0b gcd=%0d want 0/0/0",
               if16.out_valid, if16.busy, if16.gcd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (if16.in_ready !== 1'b1 || if8.in_ready !== 1'b1 || if12.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b%0b%0b want 111", if16.in_ready, if8.in_ready, if12.in_ready);
    end
    checks++;
    if (dut16.a_q !== 16'd0 || dut16.b_q !== 16'd0) begin
      errors++;
      $display("FAIL reset_ab got a=%0d b=%0d want 0/0", dut16.a_q, dut16.b_q);
    end
    $display("reset released");
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] exp_a [4];
    logic [15:0] exp_b [4];
    exp_a = '{16'd30, 16'd12, 16'd12, 16'd6};
    exp_b = '{16'd18, 16'd18, 16'd6,  16'd6};
    send16(16'd48, 16'd18);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dut16.a_q !== exp_a[i] || dut16.b_q !== exp_b[i]) begin
        errors++;
        $display("FAIL basic_step%0d got %0d/%0d want %0d/%0d", i, dut16.a_q, dut16.b_q, exp_a[i], exp_b[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (if16.out_valid !== 1'b1 || if16.gcd_out !== 16'd6) begin
      errors++;
      $display("FAIL basic_result got ov=%0b gcd=%0d want 1/6", if16.out_valid, if16.gcd_out);
    end
`ifdef GCD_ITER_COUNT_EN
    checks++;
    if (ic16 !== 16'd4) begin
      errors++;
      $display("FAIL basic_iter got %0d want 4", ic16);
    end
`endif
    $display("op16 basic a=48 b=18 gcd=%0d", if16.gcd_out);
    consume16();
  endtask

  task automatic test_zero();
    run16(16'd0, 16'd35, "zero_a");
    consume16();
    run16(16'd0, 16'd0, "zero_both");
    consume16();
    run16(16'd35, 16'd0, "zero_b");
    consume16();
  endtask

  task automatic test_hold();
    run16(16'd17, 16'd17, "equal");
    for (int i = 0; i < 10; i++) begin
      if16.in_valid = i[0];
      if16.a_in = 16'($urandom);
      if16.b_in = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (if16.out_valid !== 1'b1 || if16.gcd_out !== 16'd17 || if16.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got ov=%0b gcd=%0d rdy=%0b want 1/17/0",
                 i, if16.out_valid, if16.gcd_out, if16.in_ready);
      end
    end
    if16.in_valid = 1'b0;
    $display("hold 10 cycles gcd=%0d", if16.gcd_out);
    consume16();
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    longint unsigned exp_lat;
    run16(16'd12, 16'd8, "b2b_first");
    // Offer the next pair during the consume edge: it must not be taken there.
    if16.a_in = 16'd100;
    if16.b_in = 16'd75;
    if16.in_valid = 1'b1;
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    checks++;
    if (if16.in_ready !== 1'b1 || if16.busy !== 1'b0 || if16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got rdy=%0b busy=%0b ov=%0b want 1/0/0", if16.in_ready, if16.busy, if16.out_valid);
    end
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    checks++;
    if (if16.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%0b want 1", if16.busy);
    end
    exp_lat = ref_steps(100, 75) + 1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (if16.out_valid !== 1'b1 && lat < 1000);
    checks++;
    if (lat != int'(exp_lat) || if16.gcd_out !== 16'd25) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d gcd=%0d want %0d/25", lat, if16.gcd_out, exp_lat);
    end
    $display("op16 b2b_second a=100 b=75 gcd=%0d latency=%0d", if16.gcd_out, lat);
    consume16();
  endtask

  task automatic test_worst8();
    int lat = 0;
    if8.a_in = 8'd255;
    if8.b_in = 8'd1;
    if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (if8.out_valid !== 1'b1 && lat < 400);
    checks++;
    if (lat != 255 || if8.gcd_out !== 8'd1) begin
      errors++;
      $display("FAIL worst8 got lat=%0d gcd=%0d want 255/1", lat, if8.gcd_out);
    end
`ifdef GCD_ITER_COUNT_EN
    checks++;
    if (ic8 !== 8'd254) begin
      errors++;
      $display("FAIL worst8_iter got %0d want 254", ic8);
    end
`endif
    $display("op8 worst a=255 b=1 gcd=%0d latency=%0d", if8.gcd_out, lat);
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send16(16'd1000, 16'd7);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (if16.out_valid !== 1'b0 || if16.busy !== 1'b0 || if16.gcd_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid got ov=%0b busy=%0b gcd=%0d want 0/0/0",
               if16.out_valid, if16.busy, if16.gcd_out);
    end
    #2;
    rst_n = 1'b1;
    $display("reset pulsed mid-calc");
    @(negedge clk);
    run16(16'd12, 16'd8, "after_reset");
    consume16();
  endtask

  task automatic test_random12();
    logic [11:0] a, b, g;
    int lat, hold, bad;
    longint unsigned exp_lat, exp_g;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 15) == 0) a = 12'd0;
      if ($urandom_range(0, 15) == 0) b = 12'd0;
      if ($urandom_range(0, 15) == 0) b = a;
      exp_lat = ref_steps(a, b) + 1;
      exp_g   = ref_gcd(a, b);
      if12.a_in = a;
      if12.b_in = b;
      if12.in_valid = 1'b1;
      @(posedge clk); #1;
      if12.in_valid = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (if12.out_valid !== 1'b1 && lat < 5000);
      g = if12.gcd_out;
      checks++;
      if (lat != int'(exp_lat) || g !== 12'(exp_g)) begin
        errors++;
        $display("FAIL rand12_op%0d a=%0d b=%0d got lat=%0d gcd=%0d want %0d/%0d",
                 n, a, b, lat, g, exp_lat, exp_g);
      end
`ifdef GCD_ITER_COUNT_EN
      checks++;
      if (ic12 !== 12'(exp_lat - 1)) begin
        errors++;
        $display("FAIL rand12_iter%0d got %0d want %0d", n, ic12, exp_lat - 1);
      end
`endif
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (if12.out_valid !== 1'b1 || if12.gcd_out !== g) begin
          errors++;
          $display("FAIL rand12_hold%0d got ov=%0b gcd=%0d want 1/%0d", n, if12.out_valid, if12.gcd_out, g);
        end
      end
      if12.out_ready = 1'b1;
      @(posedge clk); #1;
      if12.out_ready = 1'b0;
      $display("op12 #%0d a=%0d b=%0d gcd=%0d latency=%0d hold=%0d", n, a, b, g, lat, hold);
    end
  endtask

  initial begin
    if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.a_in = '0; if16.b_in = '0;
    if8.in_valid  = 1'b0; if8.out_ready  = 1'b0; if8.a_in  = '0; if8.b_in  = '0;
    if12.in_valid = 1'b0; if12.out_ready = 1'b0; if12.a_in = '0; if12.b_in = '0;
    test_reset();
    test_basic();
    test_zero();
    test_hold();
    test_back_to_back();
    test_worst8();
    test_reset_mid();
    test_random12();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_unit.md
GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (unsigned; legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  unit can accept an operand pair.
REQ-006 SHALL have port a_in  input  WIDTH  operand A.
REQ-007 SHALL have port b_in  input  WIDTH  operand B.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port gcd_out  output  WIDTH  greatest common divisor.
REQ-011 SHALL have port busy  output  1  high while in CALC state.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE, busy = 1 only in CALC, out_valid = 1 only in DONE.
REQ-013 SHALL accept operands on an edge where state is IDLE and in_valid = 1: register A<=a_in, B<=b_in, state->CALC.
REQ-014 SHALL ignore in_valid and a_in/b_in in CALC and DONE (no queuing, no overwrite).
REQ-015 SHALL, on each edge in CALC, evaluate in priority: A==0 -> gcd_out<=B, DONE; B==0 -> gcd_out<=A, DONE; A==B -> gcd_out<=A, DONE; A>B -> A<=A-B; else B<=B-A.
REQ-016 SHALL perform subtraction only larger-minus-smaller, so no underflow or wrap; all arithmetic unsigned, WIDTH bits, no carry-out.
REQ-017 SHALL give latency N+1 edges from acceptance edge to out_valid rising, where N = number of subtraction steps (N=0 for zero or equal operands).
REQ-018 SHALL produce gcd(0,0)=0, gcd(0,b)=b, gcd(a,0)=a.
REQ-019 SHALL hold gcd_out and out_valid stable in DONE until an edge with out_ready = 1, then go to IDLE; out_ready outside DONE has no effect.
REQ-020 SHALL require at least one IDLE cycle between results (no accept on the DONE->IDLE edge).
REQ-021 SHALL keep gcd_out holding last result in IDLE and CALC until overwritten.
REQ-022 SHALL support worst case N = 2^WIDTH-2 (operands all-ones and 1) without error.

Reset
REQ-023 SHALL, on rst_n low, immediately (asynchronously) force state IDLE, A=0, B=0, gcd_out=0, out_valid=0, busy=0, in_ready=1 after release.
REQ-024 SHALL abandon any CALC/DONE operation on reset with no result emitted; first edge after rst_n release may accept operands.

Configuration
REQ-025 SHALL, when macro GCD_ITER_COUNT_EN is defined, add port iter_count  output  WIDTH  number of subtraction steps of current/last operation.
REQ-026 SHALL with GCD_ITER_COUNT_EN clear iter_count to 0 on reset and on acceptance, increment per subtraction step, saturate at all-ones, hold in DONE/IDLE.
REQ-027 SHALL without GCD_ITER_COUNT_EN omit iter_count port and counter logic entirely; all other behaviour identical.

Verification
REQ-028 SHALL test WIDTH=16, a=48, b=18 accepted -> A/B sequence 30/18, 12/18, 12/6, 6/6; out_valid 5 edges after accept, gcd_out=6, iter_count=4.
REQ-029 SHALL test a=0,b=35 -> out_valid 1 edge after accept, gcd_out=35, iter_count=0; then a=0,b=0 -> gcd_out=0.
REQ-030 SHALL test a=17,b=17 -> gcd_out=17 after 1 edge; then out_ready held low 10 cycles -> out_valid/gcd_out stable, in_valid pulses ignored.
REQ-031 SHALL test WIDTH=8, a=255,b=1 -> gcd_out=1 after 255 edges, iter_count=254.
REQ-032 SHALL test rst_n pulsed low mid-CALC of 1000,7 -> out_valid=0, busy=0, gcd_out=0 asynchronously; next op 12,8 -> gcd_out=4.
REQ-033 SHALL test random 1000 pairs at WIDTH=12 against a reference model, with out_ready randomly throttled.
